// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient controller: FSM encodings and tap slicing.
package fir_pkg;

  typedef enum logic [1:0] {
    FIR_CC_IDLE    = 2'd0,
    FIR_CC_LOAD    = 2'd1,
    FIR_CC_PENDING = 2'd2
  } fir_cc_state_e;

  // LSB position of tap k in a packed coefficient bus of w-bit taps.
  function automatic int unsigned fir_tap_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow and active coefficient registers: per-tap shadow write, whole-bank swap, clears.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int unsigned                     N            = 4,
  parameter int unsigned                     COEFF_WIDTH  = 8,
  parameter int unsigned                     IdxW         = (N > 1) ? $clog2(N) : 1,
  parameter logic [N*COEFF_WIDTH-1:0]        RESET_COEFFS = (N*COEFF_WIDTH)'(1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [IdxW-1:0]          wr_idx,
  input  logic [COEFF_WIDTH-1:0]   wr_data,
  input  logic                     clr,
  input  logic                     swap,
  output logic [N*COEFF_WIDTH-1:0] active
);

  logic [N*COEFF_WIDTH-1:0] shadow_q;
  logic [N*COEFF_WIDTH-1:0] active_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= RESET_COEFFS;
    end else begin
      if (clr) begin
        shadow_q <= '0;
      end else if (wr_en) begin
        shadow_q[fir_tap_lsb(32'(wr_idx), COEFF_WIDTH) +: COEFF_WIDTH] <= wr_data;
      end
      if (swap) begin
        active_q <= shadow_q;
      end
    end
  end

  assign active = active_q;

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Coefficient load controller: stages a tap set and swaps it live on a sample strobe.
// Optional readback port enabled by defining FIR_COEFF_CTRL_READBACK_EN.
module fir_coeff_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned              N            = 4,
  parameter int unsigned              COEFF_WIDTH  = 8,
  parameter logic [N*COEFF_WIDTH-1:0] RESET_COEFFS = (N*COEFF_WIDTH)'(1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [COEFF_WIDTH-1:0]   wr_data,
  input  logic                     wr_last,
  input  logic                     sample_en,
  output logic [N*COEFF_WIDTH-1:0] packed_coeffs,
  output logic                     busy,
  output logic                     swap_done,
  output logic                     err
`ifdef FIR_COEFF_CTRL_READBACK_EN
  ,
  input  logic [$clog2(N)-1:0]     rd_idx,
  output logic [COEFF_WIDTH-1:0]   rd_data
`endif
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  fir_cc_state_e   state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            err_q, err_d;
  logic            swap_done_q;
  logic            xfer;
  logic            bank_we;
  logic [IdxW-1:0] bank_idx;
  logic            bank_clr;
  logic            bank_swap;

  assign wr_ready = (state_q != FIR_CC_PENDING);
  assign xfer     = wr_valid && wr_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    bank_we   = 1'b0;
    bank_idx  = idx_q;
    bank_clr  = 1'b0;
    bank_swap = 1'b0;
    unique case (state_q)
      FIR_CC_IDLE: begin
        if (xfer) begin
          bank_we  = 1'b1;
          bank_idx = '0;
          idx_d    = IdxW'(1);
          err_d    = 1'b0;
          state_d  = (wr_last && N == 1) ? FIR_CC_PENDING : FIR_CC_LOAD;
        end
      end
      FIR_CC_LOAD: begin
        if (xfer) begin
          bank_we = 1'b1;
          if (wr_last && idx_q == IdxW'(N - 1)) begin
            state_d = FIR_CC_PENDING;
          end else if (wr_last || idx_q == IdxW'(N - 1)) begin
            // Short or long set: drop the staged words so they can never go live.
            bank_we  = 1'b0;
            bank_clr = 1'b1;
            err_d    = 1'b1;
            idx_d    = '0;
            state_d  = FIR_CC_IDLE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      FIR_CC_PENDING: begin
        if (sample_en) begin
          bank_swap = 1'b1;
          idx_d     = '0;
          state_d   = FIR_CC_IDLE;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = FIR_CC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FIR_CC_IDLE;
      idx_q       <= '0;
      err_q       <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      swap_done_q <= bank_swap;
    end
  end

  fir_coeff_bank #(
    .N            (N),
    .COEFF_WIDTH  (COEFF_WIDTH),
    .IdxW         (IdxW),
    .RESET_COEFFS (RESET_COEFFS)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bank_we),
    .wr_idx  (bank_idx),
    .wr_data (wr_data),
    .clr     (bank_clr),
    .swap    (bank_swap),
    .active  (packed_coeffs)
  );

  assign busy      = (state_q != FIR_CC_IDLE);
  assign swap_done = swap_done_q;
  assign err       = err_q;

`ifdef FIR_COEFF_CTRL_READBACK_EN
  logic [COEFF_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (32'(rd_idx) < N) begin
      rd_data_q <= packed_coeffs[fir_tap_lsb(32'(rd_idx), COEFF_WIDTH) +: COEFF_WIDTH];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Scoreboard bench for fir_coeff_ctrl: expected swaps are queued by the stimulus and
// checked by a negedge monitor that also tracks the live tap bus every cycle.
module tb_fir_coeff_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        sample_en;
  logic [31:0] packed_coeffs;
  logic        busy;
  logic        swap_done;
  logic        err;
`ifdef FIR_COEFF_CTRL_READBACK_EN
  logic [1:0]  rd_idx;
  logic [7:0]  rd_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_live = 32'h0000_0001;
  logic        rst_at_edge = 1'b0;

  always #5 clk = ~clk;

  fir_coeff_ctrl #(
    .N           (4),
    .COEFF_WIDTH (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .sample_en     (sample_en),
    .packed_coeffs (packed_coeffs),
    .busy          (busy),
    .swap_done     (swap_done),
    .err           (err)
`ifdef FIR_COEFF_CTRL_READBACK_EN
    ,
    .rd_idx        (rd_idx),
    .rd_data       (rd_data)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reset forces the model to the impulse; every swap_done must match a queued set.
  always @(posedge clk) rst_at_edge <= rst_n;

  always @(negedge clk) begin
    if (!rst_at_edge) begin
      exp_live = 32'h0000_0001;
      chk("swap_done_in_reset", {31'd0, swap_done}, 32'd0);
    end else if (swap_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_swap_done", 32'd1, 32'd0);
      end else begin
        exp_live = exp_q.pop_front();
      end
    end
    chk("packed_coeffs", packed_coeffs, exp_live);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    chk("wr_ready_before_word", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic swap(input logic [31:0] expected);
    exp_q.push_back(expected);
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    chk("wr_ready_after_swap", {31'd0, wr_ready}, 32'd1);
    chk("busy_after_swap", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_last   = 1'b0;
    sample_en = 1'b0;
`ifdef FIR_COEFF_CTRL_READBACK_EN
    rd_idx    = '0;
`endif
    step();
    step();
    chk("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Normal load: -2, -1, 3, 4 then swap three cycles later.
    send(8'hFE, 1'b0);
    chk("busy_in_load", {31'd0, busy}, 32'd1);
    send(8'hFF, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("wr_ready_pending", {31'd0, wr_ready}, 32'd0);
      step();
    end
    swap(32'h0403_FFFE);
`ifdef FIR_COEFF_CTRL_READBACK_EN
    rd_idx = 2'd1;
    step();
    chk("readback_tap1", {24'd0, rd_data}, 32'h0000_00FF);
`endif
    step();

    // Short set; a strobe in IDLE afterwards must not swap.
    send(8'h05, 1'b0);
    send(8'h06, 1'b1);
    chk("short_err", {31'd0, err}, 32'd1);
    chk("short_idle", {31'd0, busy}, 32'd0);
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    step();
    chk("short_err_sticky", {31'd0, err}, 32'd1);

    // Long set: first word clears err, fourth word without last flags it.
    send(8'h07, 1'b0);
    chk("err_cleared_first_word", {31'd0, err}, 32'd0);
    send(8'h08, 1'b0);
    send(8'h09, 1'b0);
    chk("long_err_not_yet", {31'd0, err}, 32'd0);
    send(8'h0A, 1'b0);
    chk("long_err", {31'd0, err}, 32'd1);
    chk("long_idle", {31'd0, busy}, 32'd0);
    send(8'h11, 1'b0);
    chk("fifth_word_clears_err", {31'd0, err}, 32'd0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    swap(32'h4433_2211);
    step();

    // Strobe held through LOAD (including the last-word edge) must not swap early.
    sample_en = 1'b1;
    send(8'h0A, 1'b0);
    send(8'hEC, 1'b0);
    send(8'h7F, 1'b0);
    send(8'h80, 1'b1);
    sample_en = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 8'h55;
    for (int i = 0; i < 2; i++) begin
      chk("backpressure_ready", {31'd0, wr_ready}, 32'd0);
      chk("backpressure_busy", {31'd0, busy}, 32'd1);
      step();
    end
    wr_valid = 1'b0;
    swap(32'h807F_EC0A);
    step();

    // Reset while PENDING: the staged set must be lost.
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    chk("pending_before_reset", {31'd0, wr_ready}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("post_reset_ready", {31'd0, wr_ready}, 32'd1);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_err", {31'd0, err}, 32'd0);
`ifdef FIR_COEFF_CTRL_READBACK_EN
    rd_idx = 2'd0;
    step();
    chk("readback_tap0_after_reset", {24'd0, rd_data}, 32'h0000_0001);
`endif
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    step();
    step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
